mm_loader: RTL and testbench

- Host-side feeder for the mm systolic wrapper. It is the writer end of mm's activation and weight FIFO interface.
- On start it reads FP16 activations and integer weights from two source memories.
- Activations are pushed into the per-row act FIFOs, one column k per cycle.
- Weights are serialized bit-by-bit, LSB-first, into the per-column 1-bit weight FIFOs.
- After a fixed gap it drives mm.active for K*precision cycles, then waits for mm.done and reports completion.

---
 rtl/mm_loader_if.sv | 52 +++++
 rtl/mm_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_mm_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_loader_if.sv
// -----------------------------------------------------------------------------
// mm_loader_if -- bus bundle between mm_loader and its surroundings.
//
// Groups the two source-memory read ports, the activation and weight FIFO write
// ports of the mm systolic wrapper, and the mm run/done handshake.
//
//   act_rd_addr  activation memory address (column k)
//   act_rd_data  combinational activation read, lane r = A[r][k]
//   w_rd_addr    weight memory address (column k)
//   w_rd_data    combinational weight read, lane r = W[r][k], LSB-aligned
//   act_din      activation FIFO data, one ACT_WIDTH lane per row
//   wr_en_act    activation FIFO write strobe (shared by all lanes)
//   act_full     per-lane activation FIFO full
//   w_din        weight FIFO data, one bit per column lane
//   wr_en_w      weight FIFO write strobe (shared by all lanes)
//   w_full       per-lane weight FIFO full
//   active       mm.active
//   mm_done      mm.done
//
// master: the loader side.  slave: memories, FIFOs and the mm wrapper.
// -----------------------------------------------------------------------------
interface mm_loader_if #(
  parameter int ACT_WIDTH = 16,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_PREC  = 8
);
  localparam int ADDR_W = $clog2(K) + 1;

  logic [ADDR_W-1:0]      act_rd_addr;
  logic [N*ACT_WIDTH-1:0] act_rd_data;
  logic [ADDR_W-1:0]      w_rd_addr;
  logic [N*MAX_PREC-1:0]  w_rd_data;
  logic [N*ACT_WIDTH-1:0] act_din;
  logic                   wr_en_act;
  logic [N-1:0]           act_full;
  logic [N-1:0]           w_din;
  logic                   wr_en_w;
  logic [N-1:0]           w_full;
  logic                   active;
  logic                   mm_done;

  modport master (
    output act_rd_addr, w_rd_addr, act_din, wr_en_act, w_din, wr_en_w, active,
    input  act_rd_data, w_rd_data, act_full, w_full, mm_done
  );

  modport slave (
    input  act_rd_addr, w_rd_addr, act_din, wr_en_act, w_din, wr_en_w, active,
    output act_rd_data, w_rd_data, act_full, w_full, mm_done
  );
endinterface

// File: rtl/mm_loader.sv
// -----------------------------------------------------------------------------
// mm_loader -- host-side feeder for the mm systolic wrapper.
//
// On an accepted start it copies K activation columns from the activation
// memory into the per-row act FIFOs (one column per cycle), then serialises the
// K weight columns LSB-first into the per-column 1-bit weight FIFOs (K*prec
// writes), idles GAP_CYCLES cycles, drives mm.active for K*prec cycles and waits
// for a fresh rising edge of mm.done before pulsing finish.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   start      one-cycle request, honoured only in IDLE
//   precision  weight bit count 1..MAX_PREC, latched on an accepted start
//   busy       high whenever the loader is not IDLE
//   finish     one-cycle completion pulse
//   err        sticky error; cleared by reset or the next accepted start
//   bus        mm_loader_if.master (memory reads, FIFO writes, active/done)
//
// Optional feature (macro MM_LOADER_TIMEOUT_EN): a watchdog in WAIT_DONE. If
// TIMEOUT cycles pass without a mm_done rising edge, err is set, finish pulses
// and the loader returns to IDLE. Without the macro WAIT_DONE waits forever.
// -----------------------------------------------------------------------------
module mm_loader #(
  parameter int ACT_WIDTH  = 16,
  parameter int N          = 2,
  parameter int K          = 2,
  parameter int MAX_PREC   = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  precision,
  output logic        busy,
  output logic        finish,
  output logic        err,
  mm_loader_if.master bus
);

  localparam int ADDR_W   = $clog2(K) + 1;
  localparam int P_W      = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;
  // One shared counter serves GAP, RUN and the watchdog; it is sized for the
  // largest of the three so both builds keep the same register layout.
  localparam int RUN_MAX  = K * MAX_PREC;
  localparam int CNT_MAX0 = (RUN_MAX > GAP_CYCLES) ? RUN_MAX : GAP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef MM_LOADER_TIMEOUT_EN
  localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ACT,
    LOAD_W,
    GAP,
    RUN,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;       // column index, shared by both load phases
  logic [P_W-1:0]    p_q, p_d;       // weight bit index inside a column
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // GAP / RUN / watchdog cycle counter
  logic [3:0]        prec_q, prec_d;
  logic              err_q, err_d;
  logic              done_prev_q;

  logic              prec_ok;
  logic              done_rise;
  logic [P_W-1:0]    p_last;
  logic [CNT_W-1:0]  run_last;
  logic              wr_en_act_c;
  logic              wr_en_w_c;
  logic              active_c;
  logic              finish_c;
  logic [MAX_PREC-1:0] w_lane [N];

  // ---------------------------------------------------------------------------
  // Derived conditions
  // ---------------------------------------------------------------------------
  assign prec_ok   = (precision != 4'd0) && (int'(precision) <= MAX_PREC);
  // Only a 0->1 transition seen while waiting counts; a level that was already
  // high when WAIT_DONE was entered has done_prev_q set and is ignored.
  assign done_rise = bus.mm_done & ~done_prev_q;
  assign p_last    = P_W'(prec_q - 4'd1);
  assign run_last  = CNT_W'(K) * CNT_W'(prec_q) - CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Datapath: addresses follow k, activations pass straight through, and each
  // weight lane contributes bit p of its current column.
  // ---------------------------------------------------------------------------
  assign bus.act_rd_addr = k_q;
  assign bus.w_rd_addr   = k_q;
  assign bus.act_din     = bus.act_rd_data;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_lane[r]    = bus.w_rd_data[r*MAX_PREC +: MAX_PREC];
      bus.w_din[r] = w_lane[r][p_q];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    prec_d      = prec_q;
    err_d       = err_q;
    wr_en_act_c = 1'b0;
    wr_en_w_c   = 1'b0;
    active_c    = 1'b0;
    finish_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (prec_ok) begin
            prec_d  = precision;
            err_d   = 1'b0;
            k_d     = '0;
            p_d     = '0;
            cnt_d   = '0;
            state_d = LOAD_ACT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_ACT: begin
        // A full flag on any lane stalls the shared strobe and holds k.
        if (!(|bus.act_full)) begin
          wr_en_act_c = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = LOAD_W;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      LOAD_W: begin
        // p is the inner loop (bits LSB-first), k the outer loop (columns).
        if (!(|bus.w_full)) begin
          wr_en_w_c = 1'b1;
          if (p_q == p_last) begin
            p_d = '0;
            if (k_q == K_LAST) begin
              k_d     = '0;
              cnt_d   = '0;
              state_d = (GAP_CYCLES > 0) ? GAP : RUN;
            end else begin
              k_d = k_q + 1'b1;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        active_c = 1'b1;
        if (cnt_q == run_last) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (done_rise) begin
          finish_c = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
`ifdef MM_LOADER_TIMEOUT_EN
        else if (cnt_q == WD_LAST) begin
          finish_c = 1'b1;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      prec_q      <= '0;
      err_q       <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      prec_q      <= prec_d;
      err_q       <= err_d;
      done_prev_q <= bus.mm_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.wr_en_act = wr_en_act_c;
  assign bus.wr_en_w   = wr_en_w_c;
  assign bus.active    = active_c;
  assign finish        = finish_c;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_mm_loader.sv
// -----------------------------------------------------------------------------
// tb_mm_loader -- self-checking bench for mm_loader (N=2, K=2, MAX_PREC=8).
//
// A table of run descriptions (precision, FIFO back-pressure, mm_done style and
// hand-computed phase timing) is applied one row at a time; a small memory
// model supplies expected activation columns and weight bits. Hand-written
// sequences cover reset, illegal precision, reset during the weight load and
// the WAIT_DONE watchdog (MM_LOADER_TIMEOUT_EN) or its absence.
// -----------------------------------------------------------------------------
module tb_mm_loader;

  localparam int ACT_WIDTH  = 16;
  localparam int N          = 2;
  localparam int K          = 2;
  localparam int MAX_PREC   = 8;
  localparam int GAP_CYCLES = 2;
`ifdef MM_LOADER_TIMEOUT_EN
  localparam int TIMEOUT    = 16;
`else
  localparam int TIMEOUT    = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] precision;
  logic       busy;
  logic       finish;
  logic       err;

  mm_loader_if #(.ACT_WIDTH(ACT_WIDTH), .N(N), .K(K), .MAX_PREC(MAX_PREC)) bus ();

  mm_loader #(
    .ACT_WIDTH (ACT_WIDTH),
    .N         (N),
    .K         (K),
    .MAX_PREC  (MAX_PREC),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .precision(precision),
    .busy     (busy),
    .finish   (finish),
    .err      (err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Source memories, combinational read.
  logic [ACT_WIDTH-1:0] amem [N][K];
  logic [MAX_PREC-1:0]  wmem [N][K];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      bus.act_rd_data[r*ACT_WIDTH +: ACT_WIDTH] =
        bus.act_rd_addr[1] ? '0 : amem[r][bus.act_rd_addr[0]];
      bus.w_rd_data[r*MAX_PREC +: MAX_PREC] =
        bus.w_rd_addr[1] ? '0 : wmem[r][bus.w_rd_addr[0]];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] prec;
    int         stall_at;          // first cycle with act_full[1]=1
    int         stall_len;         // number of stalled cycles (0 = none)
    bit         w_toggle;          // w_full[0]=1 on every even cycle
    bit         hold_done;         // mm_done already high before WAIT_DONE
    int         exp_w;             // weight writes
    int         exp_act_last;      // cycle of the last act write
    int         exp_w_first;       // cycle of the first weight write
    int         exp_first_active;  // first active cycle
    int         exp_active;        // active cycle count
    bit         check_seq;         // lane-0 column-0 bits must be 1,1,0,1
  } vec_t;

  vec_t tbl [6];

  // Cycle numbering: start is sampled at edge 0, cycle c follows edge c-1.
  task automatic run_row(input vec_t v, input int idx);
    int act_n, w_n, act_cnt, first_act, act_last, w_first;
    int idle_cnt, fin_cnt, edge_at, kk, pp;
    bit fin_ok, done, is_edge;
    logic [3:0] seq;
    act_n = 0; w_n = 0; act_cnt = 0; first_act = -1; act_last = -1; w_first = -1;
    idle_cnt = 0; fin_cnt = 0; fin_ok = 1'b0; done = 1'b0; seq = '0;
    edge_at = v.hold_done ? 4 : 3;

    @(negedge clk);
    start = 1'b1;
    precision = v.prec;
    bus.mm_done = v.hold_done;
    @(negedge clk);
    start = 1'b0;
    precision = 4'hF;  // later changes must not affect the latched value

    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.act_full = (v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len)
                     ? 2'b10 : 2'b00;
      bus.w_full   = (v.w_toggle && (cyc % 2 == 0)) ? 2'b01 : 2'b00;
      bus.mm_done  = v.hold_done ? (idle_cnt != 3) : (idle_cnt == 3);
      is_edge      = (idle_cnt == edge_at);
      #1;
      if (cyc == 1) begin
        check($sformatf("r%0d_err_clear", idx), err, 1'b0);
        check($sformatf("r%0d_busy_start", idx), busy, 1'b1);
      end
      if (bus.wr_en_act) begin
        if (act_n < K) begin
          check($sformatf("r%0d_act_din%0d", idx, act_n), bus.act_din,
                {amem[1][act_n], amem[0][act_n]});
          check($sformatf("r%0d_act_addr%0d", idx, act_n), bus.act_rd_addr, act_n);
        end
        act_n++;
        act_last = cyc;
      end
      if (bus.wr_en_w) begin
        if (w_first < 0) w_first = cyc;
        kk = w_n / int'(v.prec);
        pp = w_n % int'(v.prec);
        if (kk < K)
          check($sformatf("r%0d_w_din%0d", idx, w_n), bus.w_din,
                {wmem[1][kk][pp], wmem[0][kk][pp]});
        if (w_n < 4) seq[w_n] = bus.w_din[0];
        w_n++;
      end
      if (bus.active) begin
        if (first_act < 0) first_act = cyc;
        act_cnt++;
      end else if (act_cnt > 0) begin
        idle_cnt++;
      end
      if (finish) begin
        fin_cnt++;
        if (is_edge) fin_ok = 1'b1;
      end
      if (is_edge) begin
        @(negedge clk);
        bus.mm_done = 1'b0;
        #1;
        check($sformatf("r%0d_busy_after", idx), busy, 1'b0);
        check($sformatf("r%0d_finish_width", idx), finish, 1'b0);
        done = 1'b1;
      end
    end

    check($sformatf("r%0d_run_complete", idx), done, 1'b1);
    check($sformatf("r%0d_act_writes", idx), act_n, K);
    check($sformatf("r%0d_act_last", idx), act_last, v.exp_act_last);
    check($sformatf("r%0d_w_writes", idx), w_n, v.exp_w);
    check($sformatf("r%0d_w_first", idx), w_first, v.exp_w_first);
    check($sformatf("r%0d_active_first", idx), first_act, v.exp_first_active);
    check($sformatf("r%0d_active_cycles", idx), act_cnt, v.exp_active);
    check($sformatf("r%0d_finish_count", idx), fin_cnt, 1);
    check($sformatf("r%0d_finish_on_edge", idx), fin_ok, 1'b1);
    if (v.check_seq) check($sformatf("r%0d_w0_bit_order", idx), seq, 4'b1011);

    bus.act_full = '0;
    bus.w_full   = '0;
    bus.mm_done  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_finish"}, finish, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_wr_en_act"}, bus.wr_en_act, 1'b0);
    check({tag, "_wr_en_w"}, bus.wr_en_w, 1'b0);
    check({tag, "_active"}, bus.active, 1'b0);
    check({tag, "_act_addr"}, bus.act_rd_addr, 0);
    check({tag, "_w_addr"}, bus.w_rd_addr, 0);
  endtask

  task automatic illegal_start(input logic [3:0] p, input string tag);
    @(negedge clk);
    start = 1'b1;
    precision = p;
    #1;
    check({tag, "_no_act_strobe"}, bus.wr_en_act, 1'b0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_err"}, err, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_wr_en_act"}, bus.wr_en_act, 1'b0);
    check({tag, "_wr_en_w"}, bus.wr_en_w, 1'b0);
    check({tag, "_active"}, bus.active, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int wd, fin_cnt, fin_wd, act_cnt;

    amem[0][0] = 16'h3C00; amem[1][0] = 16'h4000;
    amem[0][1] = 16'h4200; amem[1][1] = 16'h4400;
    wmem[0][0] = 8'h0B;    wmem[1][0] = 8'hA5;
    wmem[0][1] = 8'h96;    wmem[1][1] = 8'h3C;

    //              prec   at len tog hold  w  aL wF  fA  act seq
    tbl[0] = '{4'd2,  0, 0, 1'b0, 1'b0,  4, 2, 3,  9,  4, 1'b0};
    tbl[1] = '{4'd4,  0, 0, 1'b0, 1'b0,  8, 2, 3, 13,  8, 1'b1};
    tbl[2] = '{4'd4,  2, 3, 1'b0, 1'b0,  8, 5, 6, 16,  8, 1'b1};
    tbl[3] = '{4'd4,  0, 0, 1'b1, 1'b0,  8, 2, 3, 20,  8, 1'b1};
    tbl[4] = '{4'd8,  0, 0, 1'b0, 1'b1, 16, 2, 3, 21, 16, 1'b0};
    tbl[5] = '{4'd1,  0, 0, 1'b0, 1'b0,  2, 2, 3,  7,  2, 1'b0};

    rst = 1'b0;
    start = 1'b0;
    precision = 4'd0;
    bus.act_full = '0;
    bus.w_full = '0;
    bus.mm_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Illegal precision: 0, then (after a reset clears err) MAX_PREC+1.
    illegal_start(4'd0, "prec0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_clears_err", err, 1'b0);
    illegal_start(4'd9, "prec9");

    // Table-driven runs; row 0 (precision 2) also shows err clearing.
    for (int i = 0; i < 6; i++) run_row(tbl[i], i);

    // Reset in the middle of the weight load.
    @(negedge clk);
    start = 1'b1;
    precision = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);   // cycle 5
    #1;
    check("midw_in_load_w", bus.wr_en_w, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("midw_reset");
    rst = 1'b1;
    run_row(tbl[1], 6);

    // WAIT_DONE with mm_done held low.
    wd = 0; fin_cnt = 0; fin_wd = -1; act_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    precision = 4'd1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      if (bus.active) act_cnt++;
      else if (act_cnt > 0) wd++;
      if (finish) begin
        fin_cnt++;
        fin_wd = wd;
      end
    end
`ifdef MM_LOADER_TIMEOUT_EN
    check("wd_finish_count", fin_cnt, 1);
    check("wd_finish_cycle", fin_wd, 16);
    check("wd_err", err, 1'b1);
    check("wd_idle", busy, 1'b0);
`else
    check("nowd_finish_count", fin_cnt, 0);
    check("nowd_busy", busy, 1'b1);
    check("nowd_err", err, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("final_reset_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
